// File: rtl/ext_mem_arb_if.sv
// rtl/ext_mem_arb_if.sv - master-side and L2-side bus bundle for ext_mem_arb
//
// Purpose: groups the per-master request buses, the broadcast response,
//   the invalidate request and the L2 front-end bus into one interface.
// Modports:
//   slave  - arbiter view: takes m_valid/m_addr/m_wdata/m_wstrb, inv_req,
//            s_rdata/s_ready; drives m_rdata/m_ready, s_valid/s_addr/s_wdata/
//            s_wstrb, s_force_inv, busy.
//   master - environment view (L1 back-ends plus L2), the mirror image.
interface ext_mem_arb_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]            m_valid;
  logic [N_MASTERS*ADDR_W-1:0]     m_addr;
  logic [N_MASTERS*DATA_W-1:0]     m_wdata;
  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb;
  logic [DATA_W-1:0]               m_rdata;
  logic [N_MASTERS-1:0]            m_ready;
  logic                            inv_req;
  logic                            s_valid;
  logic [ADDR_W-1:0]               s_addr;
  logic [DATA_W-1:0]               s_wdata;
  logic [DATA_W/8-1:0]             s_wstrb;
  logic [DATA_W-1:0]               s_rdata;
  logic                            s_ready;
  logic                            s_force_inv;
  logic                            busy;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, inv_req, s_rdata, s_ready,
    output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, s_force_inv, busy
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, inv_req, s_rdata, s_ready,
    input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, s_force_inv, busy
  );
endinterface

// File: rtl/ext_mem_arb.sv
// rtl/ext_mem_arb.sv - N-master native-bus arbiter with invalidate sequencing
//
// Purpose: merges the back-end buses of N_MASTERS L1 caches onto a single L2
//   front-end and serialises L2 force-invalidate requests so that an
//   invalidate is only issued between transactions, never inside one.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - ext_mem_arb_if.slave: master requests, broadcast m_rdata,
//          one-hot m_ready, inv_req, L2 bus, s_force_inv pulse, busy
// Configuration:
//   EXT_MEM_ARB_RR_EN defined   - round-robin arbitration starting at rr_ptr
//   EXT_MEM_ARB_RR_EN undefined - fixed priority, lowest index wins
module ext_mem_arb #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32
) (
  input logic          clk,
  input logic          rst,
  ext_mem_arb_if.slave bus
);
  localparam int SEL_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, INV} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] gnt, gnt_nxt;
  logic [SEL_W-1:0] winner;
  logic             inv_pend;

`ifdef EXT_MEM_ARB_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] ptr_nxt;

  // Pointer moves to the slot just after the master that completed.
  assign ptr_nxt = (int'(gnt) == N_MASTERS - 1) ? '0 : gnt + SEL_W'(1);

  // Scan from the highest offset down so the last hit is the one closest
  // to rr_ptr.
  always_comb begin
    int j;
    winner = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N_MASTERS) j = j - N_MASTERS;
      if (bus.m_valid[j]) winner = SEL_W'(j);
    end
  end
`else
  // Descending scan leaves the lowest asserted index as the winner.
  always_comb begin
    winner = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (bus.m_valid[k]) winner = SEL_W'(k);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      inv_pend <= 1'b0;
`ifdef EXT_MEM_ARB_RR_EN
      rr_ptr   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      // A new request arriving while INV clears the old one wins, so no
      // invalidate is ever lost.
      inv_pend <= bus.inv_req | (inv_pend & (state != INV));
`ifdef EXT_MEM_ARB_RR_EN
      if (state == BUSY && bus.s_ready) rr_ptr <= ptr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    bus.s_valid     = 1'b0;
    bus.s_addr      = '0;
    bus.s_wdata     = '0;
    bus.s_wstrb     = '0;
    bus.m_ready     = '0;
    bus.m_rdata     = '0;
    bus.s_force_inv = 1'b0;
    bus.busy        = (state != IDLE);

    case (state)
      IDLE: begin
        // Pending invalidate goes ahead of any new grant.
        if (inv_pend) begin
          state_nxt = INV;
        end else if (|bus.m_valid) begin
          gnt_nxt   = winner;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        bus.s_valid = bus.m_valid[gnt];
        bus.s_addr  = bus.m_addr[int'(gnt)*ADDR_W +: ADDR_W];
        bus.s_wdata = bus.m_wdata[int'(gnt)*DATA_W +: DATA_W];
        bus.s_wstrb = bus.m_wstrb[int'(gnt)*STRB_W +: STRB_W];
        if (bus.s_ready) begin
          bus.m_ready[gnt] = 1'b1;
          bus.m_rdata      = bus.s_rdata;
          state_nxt        = IDLE;
        end
      end
      INV: begin
        bus.s_force_inv = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ext_mem_arb.sv
// tb/tb_ext_mem_arb.sv - directed self-checking bench for ext_mem_arb
module tb_ext_mem_arb;
  localparam int N  = 2;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam logic [AW-1:0] A0 = 24'h000100;
  localparam logic [AW-1:0] A1 = 24'h00ABC4;
  localparam logic [DW-1:0] W1 = 32'h12345678;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ext_mem_arb_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus();

  ext_mem_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // {s_valid, s_force_inv, busy, m_ready[1:0]}
  logic [4:0] ctl;
  assign ctl = {bus.s_valid, bus.s_force_inv, bus.busy, bus.m_ready};

  task automatic apply_reset;
    rst = 1'b1;
    bus.m_valid = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    bus.inv_req = 1'b0; bus.s_ready = 1'b0; bus.s_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.m_valid = 2'b11; bus.m_addr = {A1, A0}; bus.s_ready = 1'b1;
    bus.s_rdata = 32'hFFFF_FFFF; bus.inv_req = 1'b1;
    bus.m_wdata = '0; bus.m_wstrb = '0;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL rst_ctl got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    chk_cnt++; if (bus.s_addr !== '0) $display("FAIL rst_saddr got %h exp 0", bus.s_addr); else pass_cnt++;
    chk_cnt++; if (bus.m_rdata !== '0) $display("FAIL rst_rdata got %h exp 0", bus.m_rdata); else pass_cnt++;
    apply_reset();
  endtask

  task automatic test_single_read;
    apply_reset();
    @(negedge clk); bus.m_valid = 2'b01; bus.m_addr = {24'h0, A0}; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t1_idle got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b10100) $display("FAIL t1_svalid got %b exp %b", ctl, 5'b10100); else pass_cnt++;
    chk_cnt++; if (bus.s_addr !== A0) $display("FAIL t1_saddr got %h exp %h", bus.s_addr, A0); else pass_cnt++;
    chk_cnt++; if (bus.s_wstrb !== 4'h0) $display("FAIL t1_wstrb got %h exp 0", bus.s_wstrb); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b10100) $display("FAIL t1_wait got %b exp %b", ctl, 5'b10100); else pass_cnt++;
    @(negedge clk); bus.s_ready = 1'b1; bus.s_rdata = 32'hDEADBEEF; #1;
    chk_cnt++; if (ctl !== 5'b10101) $display("FAIL t1_ready got %b exp %b", ctl, 5'b10101); else pass_cnt++;
    chk_cnt++; if (bus.m_rdata !== 32'hDEADBEEF) $display("FAIL t1_rdata got %h exp deadbeef", bus.m_rdata); else pass_cnt++;
    @(negedge clk); bus.s_ready = 1'b0; bus.s_rdata = '0; bus.m_valid = 2'b00; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t1_bubble got %b exp %b", ctl, 5'b00000); else pass_cnt++;
  endtask

  task automatic test_contention;
    int exp_m;
    logic [AW-1:0] exp_a;
    logic [4:0] exp_ctl;
    apply_reset();
    @(negedge clk);
    bus.m_valid = 2'b11; bus.m_addr = {A1, A0};
    bus.m_wdata = {W1, 32'h0}; bus.m_wstrb = {4'hF, 4'h0};
    for (int i = 0; i < 4; i++) begin
`ifdef EXT_MEM_ARB_RR_EN
      exp_m = i % 2;
`else
      exp_m = 0;
`endif
      exp_a   = (exp_m == 1) ? A1 : A0;
      exp_ctl = (exp_m == 1) ? 5'b10110 : 5'b10101;
      @(negedge clk); #1;
      chk_cnt++; if (bus.s_addr !== exp_a) $display("FAIL cont%0d_addr got %h exp %h", i, bus.s_addr, exp_a); else pass_cnt++;
      chk_cnt++; if (bus.s_wstrb !== ((exp_m == 1) ? 4'hF : 4'h0)) $display("FAIL cont%0d_wstrb got %h exp master %0d", i, bus.s_wstrb, exp_m); else pass_cnt++;
      bus.s_ready = 1'b1; bus.s_rdata = 32'(i + 32'hA0); #1;
      chk_cnt++; if (ctl !== exp_ctl) $display("FAIL cont%0d_ready got %b exp %b", i, ctl, exp_ctl); else pass_cnt++;
      chk_cnt++; if (bus.m_rdata !== 32'(i + 32'hA0)) $display("FAIL cont%0d_rdata got %h exp %h", i, bus.m_rdata, 32'(i + 32'hA0)); else pass_cnt++;
      @(negedge clk); bus.s_ready = 1'b0; #1;
      chk_cnt++; if (ctl !== 5'b00000) $display("FAIL cont%0d_bubble got %b exp %b", i, ctl, 5'b00000); else pass_cnt++;
    end
    bus.m_valid = 2'b10;
    @(negedge clk); #1;
    chk_cnt++; if (bus.s_addr !== A1) $display("FAIL cont_drop_addr got %h exp %h", bus.s_addr, A1); else pass_cnt++;
    chk_cnt++; if (bus.s_wdata !== W1) $display("FAIL cont_drop_wdata got %h exp %h", bus.s_wdata, W1); else pass_cnt++;
    bus.s_ready = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b10110) $display("FAIL cont_drop_ready got %b exp %b", ctl, 5'b10110); else pass_cnt++;
    @(negedge clk); bus.s_ready = 1'b0; bus.m_valid = 2'b00;
  endtask

  task automatic test_inv_busy;
    apply_reset();
    @(negedge clk); bus.m_valid = 2'b01; bus.m_addr = {24'h0, 24'h000200};
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b10100) $display("FAIL t4_svalid got %b exp %b", ctl, 5'b10100); else pass_cnt++;
    @(negedge clk); bus.inv_req = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b10100) $display("FAIL t4_inv_in_busy got %b exp %b", ctl, 5'b10100); else pass_cnt++;
    @(negedge clk); bus.inv_req = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.s_ready = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b10101) $display("FAIL t4_ready got %b exp %b", ctl, 5'b10101); else pass_cnt++;
    @(negedge clk); bus.s_ready = 1'b0; bus.m_valid = 2'b00; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t4_idle got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b01100) $display("FAIL t4_inv got %b exp %b", ctl, 5'b01100); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t4_after got %b exp %b", ctl, 5'b00000); else pass_cnt++;
  endtask

  task automatic test_inv_edges;
    apply_reset();
    @(negedge clk); bus.m_valid = 2'b01; bus.m_addr = {24'h0, 24'h000300};
    @(negedge clk); bus.s_ready = 1'b1; bus.inv_req = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b10101) $display("FAIL edge_ready_inv got %b exp %b", ctl, 5'b10101); else pass_cnt++;
    @(negedge clk); bus.s_ready = 1'b0; bus.inv_req = 1'b0; bus.m_valid = 2'b00; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL edge_idle got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); bus.inv_req = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b01100) $display("FAIL edge_inv1 got %b exp %b", ctl, 5'b01100); else pass_cnt++;
    @(negedge clk); bus.inv_req = 1'b0; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL edge_idle2 got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b01100) $display("FAIL edge_inv2 got %b exp %b", ctl, 5'b01100); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL edge_idle3 got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL edge_no_third got %b exp %b", ctl, 5'b00000); else pass_cnt++;
  endtask

  task automatic test_inv_vs_req;
    apply_reset();
    @(negedge clk); bus.inv_req = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t5_c0 got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); bus.inv_req = 1'b0; bus.m_valid = 2'b10;
    bus.m_addr = {A1, 24'h0}; bus.m_wdata = {W1, 32'h0}; bus.m_wstrb = {4'hF, 4'h0}; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t5_idle_pend got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b01100) $display("FAIL t5_inv_first got %b exp %b", ctl, 5'b01100); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t5_idle got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b10100) $display("FAIL t5_grant got %b exp %b", ctl, 5'b10100); else pass_cnt++;
    chk_cnt++; if (bus.s_addr !== A1) $display("FAIL t5_addr got %h exp %h", bus.s_addr, A1); else pass_cnt++;
    bus.s_ready = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b10110) $display("FAIL t5_ready got %b exp %b", ctl, 5'b10110); else pass_cnt++;
    @(negedge clk); bus.s_ready = 1'b0; bus.m_valid = 2'b00;
  endtask

  task automatic test_reset_mid_busy;
    apply_reset();
    @(negedge clk); bus.m_valid = 2'b01; bus.m_addr = {24'h0, A0}; bus.m_wstrb = '0;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b10100) $display("FAIL t6_busy got %b exp %b", ctl, 5'b10100); else pass_cnt++;
    bus.s_ready = 1'b1; bus.s_rdata = 32'hCAFE0001; #1;
    chk_cnt++; if (ctl !== 5'b10101) $display("FAIL t6_ready got %b exp %b", ctl, 5'b10101); else pass_cnt++;
    #1 rst = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t6_async got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    chk_cnt++; if (bus.s_addr !== '0) $display("FAIL t6_saddr got %h exp 0", bus.s_addr); else pass_cnt++;
    chk_cnt++; if (bus.m_rdata !== '0) $display("FAIL t6_rdata got %h exp 0", bus.m_rdata); else pass_cnt++;
    bus.s_ready = 1'b0; bus.s_rdata = '0;
    @(negedge clk); rst = 1'b0; #1;
    chk_cnt++; if (ctl !== 5'b00000) $display("FAIL t6_rel_idle got %b exp %b", ctl, 5'b00000); else pass_cnt++;
    @(negedge clk); #1;
    chk_cnt++; if (ctl !== 5'b10100) $display("FAIL t6_regrant got %b exp %b", ctl, 5'b10100); else pass_cnt++;
    chk_cnt++; if (bus.s_addr !== A0) $display("FAIL t6_addr got %h exp %h", bus.s_addr, A0); else pass_cnt++;
    bus.s_ready = 1'b1; #1;
    chk_cnt++; if (ctl !== 5'b10101) $display("FAIL t6_done got %b exp %b", ctl, 5'b10101); else pass_cnt++;
    @(negedge clk); bus.s_ready = 1'b0; bus.m_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_inv_busy();
    test_inv_edges();
    test_inv_vs_req();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
